// File: rtl/bin_img_reader.sv
// rtl/bin_img_reader.sv - streams one image frame from RAM to the moment calculator and captures its result
module bin_img_reader #(
  parameter int ADDR_W    = 10,
  parameter int NUM_WORDS = 640,
  parameter int TIMEOUT   = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [7:0]        ram_rdata,
  output logic              cnt_en,
  output logic [7:0]        data_out,
  output logic              rd_done,
  input  logic [31:0]       m00_in,
  input  logic              m00_done,
  output logic [31:0]       m00_result,
  output logic              result_valid,
  output logic              busy,
  output logic              timeout_err
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);
  localparam int                TW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]     LAST_WAIT = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, WAIT_RES} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rd_en_q, rd_en_d;
  logic [7:0]        data_q, data_d;
  logic              drain_q, drain_d;
  logic [TW-1:0]     wait_q, wait_d;
  logic [31:0]       m00_q, m00_d;
  logic              rv_q, rv_d;
  logic              terr_q, terr_d;

  // Next-state logic, strobes decoded from state, and the two-stage data pipe
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    drain_d   = drain_q;
    wait_d    = wait_q;
    m00_d     = m00_q;
    rv_d      = 1'b0;
    terr_d    = terr_q;
    ram_rd_en = 1'b0;
    cnt_en    = 1'b0;
    rd_done   = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_en = 1'b1;
        if (start) begin
          state_d = READ;
          addr_d  = '0;
          terr_d  = 1'b0;
        end
      end
      READ: begin
        ram_rd_en = 1'b1;
        if (addr_q == LAST_ADDR) begin
          state_d = DRAIN;
          drain_d = 1'b0;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
        end
      end
      DRAIN: begin
        // The last RAM word reaches data_out during the second drain cycle
        rd_done = drain_q;
        if (drain_q) begin
          state_d = WAIT_RES;
          wait_d  = '0;
        end else begin
          drain_d = 1'b1;
        end
      end
      WAIT_RES: begin
        if (m00_done) begin
          m00_d   = m00_in;
          rv_d    = 1'b1;
          state_d = IDLE;
        end else if (wait_q == LAST_WAIT) begin
          terr_d  = 1'b1;
          state_d = IDLE;
        end else begin
          wait_d = wait_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // RAM answers one cycle after the strobe; data_out registers it one cycle later
    rd_en_d = ram_rd_en;
    data_d  = rd_en_q ? ram_rdata : 8'h00;

    // Abort discards everything in flight, including a same-cycle start or result
    if (abort) begin
      state_d = IDLE;
      addr_d  = addr_q;
      rd_en_d = 1'b0;
      data_d  = 8'h00;
      m00_d   = m00_q;
      rv_d    = 1'b0;
      terr_d  = terr_q;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rd_en_q <= 1'b0;
      data_q  <= 8'h00;
      drain_q <= 1'b0;
      wait_q  <= '0;
      m00_q   <= '0;
      rv_q    <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rd_en_q <= rd_en_d;
      data_q  <= data_d;
      drain_q <= drain_d;
      wait_q  <= wait_d;
      m00_q   <= m00_d;
      rv_q    <= rv_d;
      terr_q  <= terr_d;
    end
  end

  assign ram_addr     = addr_q;
  assign data_out     = data_q;
  assign m00_result   = m00_q;
  assign result_valid = rv_q;
  assign timeout_err  = terr_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_bin_img_reader.sv
// tb/tb_bin_img_reader.sv - scoreboard bench for bin_img_reader
module tb_bin_img_reader;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst, start, abort, m00_done;
  logic        ram_rd_en, cnt_en, rd_done, result_valid, busy, timeout_err;
  logic [9:0]  ram_addr;
  logic [7:0]  ram_rdata, data_out;
  logic [31:0] m00_in, m00_result;

  logic        start1, rd_en1, cnt_en1, rd_done1, rv1, busy1, terr1;
  logic [0:0]  addr1;
  logic [7:0]  rdata1, data1;
  logic [31:0] m00_res1;

  logic [7:0]  mem [N];
  logic [7:0]  exp_q[$];
  logic [31:0] res_q[$];
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  bin_img_reader #(.ADDR_W(10), .NUM_WORDS(N), .TIMEOUT(64)) u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .ram_rd_en(ram_rd_en), .ram_addr(ram_addr), .ram_rdata(ram_rdata),
    .cnt_en(cnt_en), .data_out(data_out), .rd_done(rd_done),
    .m00_in(m00_in), .m00_done(m00_done), .m00_result(m00_result),
    .result_valid(result_valid), .busy(busy), .timeout_err(timeout_err)
  );

  bin_img_reader #(.ADDR_W(1), .NUM_WORDS(1), .TIMEOUT(64)) u_one (
    .clk(clk), .rst(rst), .start(start1), .abort(1'b0),
    .ram_rd_en(rd_en1), .ram_addr(addr1), .ram_rdata(rdata1),
    .cnt_en(cnt_en1), .data_out(data1), .rd_done(rd_done1),
    .m00_in(32'h0), .m00_done(1'b0), .m00_result(m00_res1),
    .result_valid(rv1), .busy(busy1), .timeout_err(terr1)
  );

  // Image RAM models; non-read cycles return junk that must never leak to data_out
  always @(posedge clk) begin
    ram_rdata <= ram_rd_en ? mem[ram_addr[1:0]] : 8'h5A;
    rdata1    <= rd_en1 ? 8'hAA : 8'h5A;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_reset();
    check("rst_cnt_en", cnt_en, 1);
    check("rst_rd_en", ram_rd_en, 0);
    check("rst_addr", ram_addr, 0);
    check("rst_data", data_out, 0);
    check("rst_rd_done", rd_done, 0);
    check("rst_m00", m00_result, 0);
    check("rst_rv", result_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_terr", timeout_err, 0);
  endtask

  task automatic run_frame(input bit hold, input bit give, input logic [31:0] res);
    logic [31:0] prev;
    int          n;
    start = 1'b1;
    for (int i = 0; i < N; i++) exp_q.push_back(mem[i]);
    @(negedge clk);
    if (!hold) start = 1'b0;
    for (int k = 1; k <= N + 2; k++) begin
      check("rd_en", ram_rd_en, 32'(k <= N));
      if (k <= N) check("addr", ram_addr, 32'(k - 1));
      check("cnt_en_frame", cnt_en, 0);
      check("busy_frame", busy, 1);
      check("terr_cleared", timeout_err, 0);
      if (k >= 3) begin
        if (exp_q.size() == 0) check("sb_underflow", 1, 0);
        else check("data", data_out, 32'(exp_q.pop_front()));
      end else begin
        check("data_lead", data_out, 0);
      end
      check("rd_done", rd_done, 32'(k == N + 2));
      @(negedge clk);
    end
    check("wait_data", data_out, 0);
    check("wait_cnt_en", cnt_en, 0);
    check("wait_busy", busy, 1);
    check("wait_rd_en", ram_rd_en, 0);
    check("addr_hold", ram_addr, N - 1);
    if (give) begin
      res_q.push_back(res);
      m00_in   = res;
      m00_done = 1'b1;
      start    = 1'b0;
      @(negedge clk);
      m00_done = 1'b0;
      check("rv_pulse", result_valid, 1);
      check("m00_result", m00_result, res_q.pop_front());
      check("idle_busy", busy, 0);
      check("idle_cnt_en", cnt_en, 1);
      @(negedge clk);
      check("rv_single", result_valid, 0);
      check("no_restart", busy, 0);
    end else begin
      prev  = m00_result;
      start = 1'b0;
      n     = 1;
      while (busy && n < 200) begin
        @(negedge clk);
        check("to_no_rv", result_valid, 0);
        if (busy) n++;
      end
      check("to_cycles", n, 64);
      check("to_err", timeout_err, 1);
      check("to_m00_kept", m00_result, prev);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  initial begin
    mem[0] = 8'hFF; mem[1] = 8'h01; mem[2] = 8'h00; mem[3] = 8'h80;
    rst = 1'b1; start = 1'b0; abort = 1'b0; m00_done = 1'b0; m00_in = '0; start1 = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset();
    rst = 1'b0;

    // result pulse while idle is ignored
    m00_in = 32'd99; m00_done = 1'b1;
    @(negedge clk);
    m00_done = 1'b0;
    check("idle_m00_rv", result_valid, 0);
    check("idle_m00_val", m00_result, 0);
    check("idle_m00_busy", busy, 0);

    run_frame(1'b0, 1'b1, 32'd10);
    run_frame(1'b1, 1'b1, 32'd20);
    run_frame(1'b0, 1'b0, 32'd0);

    // abort while word 2 is being addressed
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("ab_addr", ram_addr, 2);
    check("ab_terr_cleared", timeout_err, 0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("ab_cnt_en", cnt_en, 1);
    check("ab_data", data_out, 0);
    check("ab_rd_en", ram_rd_en, 0);
    check("ab_busy", busy, 0);
    for (int i = 0; i < 4; i++) begin
      check("ab_rd_done", rd_done, 0);
      @(negedge clk);
      check("ab_data_flush", data_out, 0);
    end

    // reset during DRAIN, then a clean frame
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (N) @(negedge clk);
    check("drain_rd_en", ram_rd_en, 0);
    check("drain_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    chk_reset();
    rst = 1'b0;
    exp_q.delete();
    run_frame(1'b0, 1'b1, 32'd30);

    // single-word frame
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    check("one_rd_en", rd_en1, 1);
    check("one_addr", addr1, 0);
    check("one_data0", data1, 0);
    @(negedge clk);
    check("one_rd_en_off", rd_en1, 0);
    check("one_data1", data1, 0);
    check("one_done_early", rd_done1, 0);
    @(negedge clk);
    check("one_data", data1, 32'hAA);
    check("one_rd_done", rd_done1, 1);
    @(negedge clk);
    check("one_data_after", data1, 0);
    check("one_done_after", rd_done1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bin_img_reader.md
BIN_IMG_READER -- requirements
Module: bin_img_reader

Interface
REQ-001 Parameter ADDR_W, default 10, SHALL set the width of the image RAM word address.
REQ-002 Parameter NUM_WORDS, default 640, SHALL set the number of 8-bit words per frame (range 1..2^ADDR_W).
REQ-003 Parameter TIMEOUT, default 64, SHALL set the maximum number of cycles spent waiting for the moment result.
REQ-004 The block SHALL have one clock, clk; the reset, rst, SHALL be synchronous and active-high.
REQ-005 Port list (name, direction, width, meaning):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle frame request
- abort  in  1  return to IDLE immediately
- ram_rd_en  out  1  image RAM read strobe
- ram_addr  out  ADDR_W  image RAM word address
- ram_rdata  in  8  RAM data, valid one cycle after ram_rd_en
- cnt_en  out  1  accumulator clear to moment calculator, high = clear
- data_out  out  8  pixel byte to moment calculator, 0 when not valid
- rd_done  out  1  one-cycle end-of-frame pulse
- m00_in  in  32  moment result from calculator
- m00_done  in  1  result-valid pulse from calculator
- m00_result  out  32  captured frame moment
- result_valid  out  1  one-cycle pulse, m00_result updated
- busy  out  1  high in every state except IDLE
- timeout_err  out  1  sticky, set on result timeout

Function
REQ-006 FSM states SHALL be IDLE, READ, DRAIN, WAIT_RES.
REQ-007 IDLE: cnt_en=1, ram_rd_en=0, data_out=0; start=1 -> READ, ram_addr=0, timeout_err cleared.
REQ-008 start SHALL be ignored outside IDLE.
REQ-009 READ: ram_rd_en=1 every cycle, cnt_en=0; ram_addr increments by 1 per cycle from 0 to NUM_WORDS-1; after issuing NUM_WORDS-1 -> DRAIN.
REQ-010 data_out SHALL be registered: data_out <= ram_rdata when ram_rd_en was high two cycles earlier, else 0; latency address-to-data_out = 2 cycles.
REQ-011 DRAIN SHALL last exactly 2 cycles, ram_rd_en=0, cnt_en=0; rd_done SHALL pulse in the same cycle that the last valid byte is on data_out.
REQ-012 Exactly NUM_WORDS nonzero-capable bytes SHALL appear on data_out per frame; all other cycles data_out=0 (consumer accumulates every cycle with cnt_en=0).
REQ-013 WAIT_RES: cnt_en=0, data_out=0; on m00_done=1 capture m00_in into m00_result, pulse result_valid for one cycle, -> IDLE.
REQ-014 WAIT_RES SHALL count cycles; after TIMEOUT cycles without m00_done -> IDLE with timeout_err=1, m00_result unchanged, no result_valid.
REQ-015 m00_done outside WAIT_RES SHALL be ignored.
REQ-016 abort=1 in any state SHALL force IDLE next cycle: ram_rd_en=0, data_out=0, rd_done=0, cnt_en=1; abort has priority over start, m00_done and timeout.
REQ-017 NUM_WORDS=1: READ lasts one cycle, then DRAIN; rd_done coincides with the single data byte.
REQ-018 ram_addr SHALL hold its last value outside READ; no wrap past NUM_WORDS-1.

Reset
REQ-019 rst=1 SHALL force IDLE and, next cycle: cnt_en=1, ram_rd_en=0, ram_addr=0, data_out=0, rd_done=0, m00_result=0, result_valid=0, busy=0, timeout_err=0.
REQ-020 rst SHALL have priority over abort and all other inputs, including mid-frame.

Verification
REQ-021 NUM_WORDS=4, RAM = 0xFF,0x01,0x00,0x80; start -> data_out sequence FF,01,00,80 on four consecutive cycles 3..6 after start, rd_done with 0x80; model calculator returns 10 -> m00_result=10, result_valid pulse.
REQ-022 start held high during READ -> single frame only, ram_addr 0..NUM_WORDS-1 once.
REQ-023 abort during READ at word 2 -> cnt_en=1, data_out=0 next cycle, no rd_done, busy=0.
REQ-024 m00_done never returned, TIMEOUT=64 -> IDLE after 64 WAIT_RES cycles, timeout_err=1, m00_result unchanged.
REQ-025 NUM_WORDS=1, RAM=0xAA -> one data byte 0xAA with rd_done in same cycle.
REQ-026 rst asserted in DRAIN -> all outputs at REQ-019 values next cycle; subsequent start runs a full clean frame.
